// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply, restoring divide,
// sign fix-up, and HI/LO result registers, sequenced by a small FSM.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       state_dbg
);

  // Handshake: start is taken only in IDLE when flush is low; exactly one done pulse
  // follows per accepted start unless flush or reset aborts it; hi/lo are valid from done on.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic               is_signed;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] product;

  assign is_signed = ~op_q[0];
  // Multiply: a_q holds the multiplier shifting out, acc_q the upper product half.
  assign mul_sum   = {1'b0, acc_q} + (a_q[0] ? {1'b0, b_q} : '0);
  // Divide: a_q holds the dividend shifting out and the quotient shifting in.
  assign div_trial = {acc_q, a_q[WIDTH-1]} - {1'b0, b_q};
  assign product   = {acc_q, a_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          a_d     = opa;
          b_d     = opb;
          acc_d   = '0;
          dz_d    = 1'b0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          sa_d  = is_signed & a_q[WIDTH-1];
          sb_d  = is_signed & b_q[WIDTH-1];
          a_d   = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
          b_d   = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
          acc_d = '0;
          cnt_d = '0;
          if (op_q[1] && (b_q == '0)) begin
            hi_d    = a_q;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            if (!div_trial[WIDTH]) begin
              acc_d = div_trial[WIDTH-1:0];
              a_d   = {a_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
              a_d   = {a_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            {acc_d, a_d} = {mul_sum, a_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            lo_d = (sa_q ^ sb_q) ? -a_q : a_q;
            hi_d = sa_q ? -acc_q : acc_q;
          end else begin
            {hi_d, lo_d} = (sa_q ^ sb_q) ? -product : product;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = (state_q == S_DONE) && dz_q;
  assign stall       = ((state_q == S_IDLE) && start && !flush) ||
                       (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, flush;
  logic [1:0]   op;
  logic [W-1:0] opa, opb;
  logic         stall, busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  logic [2:0]   state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*W:0] exp_q[$];   // {div_by_zero, hi, lo}
  logic [W-1:0] cur_hi, cur_lo;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .stall(stall), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint       sa, sb, q, r;
    logic [63:0]  p;
    logic [63:0]  ua, ub;
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (o)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end
      2'b01: p = ua * ub;
      2'b10: begin
        if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        p  = {r[31:0], q[31:0]};
      end
      default: begin
        if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
        p = {a % b, a / b};
      end
    endcase
    return {1'b0, p};
  endfunction

  // ---------------- driver ----------------
  // Launches one op in cycle 0 and follows it to its done cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold);
    logic [2*W:0] e;
    int           lat;
    exp_q.push_back(model(o, a, b));
    lat = (o[1] && b == '0) ? 2 : W + 3;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    #1;
    check("stall_c0", stall, 1'b1);
    check("done_c0", done, 1'b0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      #1;
      if (c < lat) begin
        check("stall_run", stall, 1'b1);
        check("done_early", done, 1'b0);
        if (c == lat - 1) begin
          check("hi_hold", hi, cur_hi);
          check("lo_hold", lo, cur_lo);
        end
      end else begin
        e = exp_q.pop_front();
        check("done", done, 1'b1);
        check("stall_done", stall, 1'b0);
        check("dbz", div_by_zero, e[2*W]);
        check("hi", hi, e[2*W-1:W]);
        check("lo", lo, e[W-1:0]);
        cur_hi = e[2*W-1:W];
        cur_lo = e[W-1:0];
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; opa = '0; opb = '0;
    cur_hi = '0; cur_lo = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_stall", stall, 1'b0);
    rst_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    run_op(2'b00, -32'sd3, 32'd7, 1'b0);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);
    run_op(2'b01, 32'h1_0000, 32'h1_0000, 1'b0);
    check("multu_carry_hi", hi, 32'h1);
    run_op(2'b10, -32'sd7, 32'd2, 1'b0);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo", lo, 32'h8000_0000);
    run_op(2'b11, 32'd5, 32'd0, 1'b0);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    check("divu_hi", hi, 32'd2);

    // flush in cycle 10 of a mult: aborts, no done, hi/lo unchanged
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 32'd123; opb = 32'd456;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", busy, 1'b0);
    check("flush_stall", stall, 1'b0);
    check("flush_hi", hi, 32'd2);
    check("flush_lo", lo, 32'd14);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check("flush_no_done", done, 1'b0);
    end

    // start held high through an op, then another op right after done
    run_op(2'b00, 32'd9, -32'sd11, 1'b1);
    run_op(2'b11, 32'd1000, 32'd33, 1'b0);

    // start together with flush in IDLE is dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    #1;
    check("sf_stall", stall, 1'b0);
    @(negedge clk);
    check("sf_busy", busy, 1'b0);
    start = 1'b0; flush = 1'b0;

    // randomized ops
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = W'($urandom_range(0, 200)); rb = W'($urandom_range(1, 15)); end
        2: rb = -W'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(ro, ra, rb, bit'($urandom_range(0, 1)));
    end

    // reset mid-RUN returns everything to zero at once
    @(negedge clk);
    start = 1'b1; op = 2'b01; opa = 32'hDEAD_BEEF; opb = 32'h1234_5678;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_hi", hi, '0);
    check("mrst_lo", lo, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_hi = '0; cur_lo = '0;
    run_op(2'b10, 32'd77, -32'sd5, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
